ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter for the VT52 terminal keyboard port. It sends command bytes to the keyboard, such as set-LEDs 0xED followed by its LED mask, using the PS/2 host-request protocol. It drives the shared PS/2 clock and data lines through open-drain enables, next to the existing PS/2 receiver. While it owns the bus it tells that receiver to ignore line activity.

---
 rtl/ps2_host_tx.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ------------------------------------------------------------------------
// ps2_host_tx: PS/2 host-to-device command transmitter (open-drain drive).
// Revision 1.0
// ------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2800,
  parameter int SETUP_CYCLES   = 32,
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 378000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       rx_inhibit,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int MAX_A   = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int CNT_MAX = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int FW      = $clog2(FILTER_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_SEND      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_DONE      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  logic [1:0] raw;
  logic [1:0] filt;
  logic [1:0] chg;
  assign raw = {ps2_data_in, ps2_clk_in};

  // Index 0 is the clock line, index 1 the data line; both idle high.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_line
    logic [1:0]    sync_q;
    logic [FW-1:0] fcnt_q;
    logic          filt_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q <= 2'b11;
        fcnt_q <= '0;
        filt_q <= 1'b1;
      end else begin
        sync_q <= {sync_q[0], raw[gi]};
        if (sync_q[1] == filt_q) begin
          fcnt_q <= '0;
        end else if (fcnt_q == FW'(FILTER_CYCLES - 1)) begin
          fcnt_q <= '0;
          filt_q <= sync_q[1];
        end else begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end
    end

    assign chg[gi]  = (sync_q[1] != filt_q) && (fcnt_q == FW'(FILTER_CYCLES - 1));
    assign filt[gi] = filt_q;
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    frame_q, frame_d;
  logic          fall_q;
  logic          clk_oe_q, data_oe_q, data_oe_d;
  logic          ready_q, inhibit_q, done_q, error_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      fall_q    <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b0;
      inhibit_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      fall_q    <= chg[0] & filt[0];
      clk_oe_q  <= (state_d == S_INHIBIT) || (state_d == S_REQ);
      data_oe_q <= data_oe_d;
      ready_q   <= (state_d == S_IDLE);
      inhibit_q <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      error_q   <= (state_d == S_ERROR);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    data_oe_d = data_oe_q;
    case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid && ready_q) begin
          frame_d = {~^tx_data, tx_data};
          cnt_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REQ: begin
        if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEND: begin
        cnt_d = cnt_q + 1'b1;
        if (fall_q) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          // Tenth edge carries the stop bit: release data and await the ACK.
          if (bit_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end else begin
            data_oe_d = ~frame_q[0];
            frame_d   = {1'b0, frame_q[8:1]};
          end
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERROR;
        end
      end
      S_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (fall_q) begin
          cnt_d   = '0;
          state_d = filt[1] ? S_ERROR : S_WAIT_IDLE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERROR;
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = cnt_q + 1'b1;
        if (filt[0] && filt[1]) begin
          state_d = S_DONE;
        end else if (fall_q) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERROR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ERROR) data_oe_d = 1'b0;
  end

  assign tx_ready    = ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign rx_inhibit  = inhibit_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ------------------------------------------------------------------------
// tb_ps2_host_tx: directed bench with an open-drain PS/2 device model.
// Revision 1.0
// ------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int SET  = 8;
  localparam int FIL  = 4;
  localparam int TOUT = 1000;
  localparam int HALF = 40;

  // Captured frame: [0] start, [8:1] data LSB first, [9] parity, [10] stop.
  localparam logic [7:0]  BYTES  [4] = '{8'hED, 8'h00, 8'h01, 8'hF4};
  localparam logic [10:0] FRAMES [4] = '{11'h7DA, 11'h600, 11'h402, 11'h5E8};

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       rx_inhibit, tx_done, tx_error;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic glitch_low   = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .SETUP_CYCLES   (SET),
    .FILTER_CYCLES  (FIL),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .rx_inhibit  (rx_inhibit),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_done = 0;
  int   n_errp = 0;
  int   err_cyc = 0;
  int   rel_cyc = 0;
  logic err_clk_oe, err_data_oe;
  logic pulse_prev = 1'b0;
  logic ready_after;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pulse_prev <= tx_done | tx_error;
    if (pulse_prev) ready_after <= tx_ready;
    if (tx_done) n_done <= n_done + 1;
    if (tx_error) begin
      n_errp      <= n_errp + 1;
      err_cyc     <= cyc;
      err_clk_oe  <= ps2_clk_oe;
      err_data_oe <= ps2_data_oe;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_byte(input logic [7:0] b, input string tag);
    int k;
    int oe_cyc;
    k = 0;
    while (!tx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, " ready before"}, {31'd0, tx_ready}, 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check({tag, " ready after accept"}, {31'd0, tx_ready}, 32'd0);
    check({tag, " rx_inhibit"}, {31'd0, rx_inhibit}, 32'd1);
    oe_cyc = 0;
    while (ps2_clk_oe && oe_cyc < 5000) begin
      oe_cyc++;
      @(negedge clk);
    end
    check({tag, " clk_oe cycles"}, oe_cyc, INH + SET);
    rel_cyc = cyc;
  endtask

  task automatic dev_frame(input int npulse, input bit ack, input bit glitch,
                           output logic [10:0] bits);
    bits    = '0;
    bits[0] = ps2_data_in;
    repeat (HALF) @(negedge clk);
    for (int i = 1; i <= npulse; i++) begin
      if (i == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (10) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (glitch && i <= 10) begin
        repeat (10) @(negedge clk);
        glitch_low = 1'b1;
        repeat (3) @(negedge clk);
        glitch_low = 1'b0;
        repeat (HALF - 13) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (i <= 10) bits[i] = ps2_data_in;
      if (i == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_result(input int d0, input int e0, input string tag);
    int k;
    k = 0;
    while (n_done == d0 && n_errp == e0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) check({tag, " result timeout"}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [10:0] bits;
    int          d0, e0;

    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("reset data_oe", {31'd0, ps2_data_oe}, 32'd0);
    check("reset tx_ready", {31'd0, tx_ready}, 32'd0);
    check("reset rx_inhibit", {31'd0, rx_inhibit}, 32'd0);
    check("reset pulses", {30'd0, tx_done, tx_error}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready after reset", {31'd0, tx_ready}, 32'd1);

    // Normal frames with ACK, including parity corner cases.
    for (int i = 0; i < 4; i++) begin
      d0 = n_done;
      e0 = n_errp;
      start_byte(BYTES[i], "ack");
      dev_frame(11, 1'b1, 1'b0, bits);
      wait_result(d0, e0, "ack");
      check($sformatf("frame %02h", BYTES[i]), {21'd0, bits}, {21'd0, FRAMES[i]});
      check($sformatf("parity %02h", BYTES[i]), {31'd0, bits[9]}, {31'd0, FRAMES[i][9]});
      check("done count", n_done - d0, 1);
      check("error count", n_errp - e0, 0);
      check("ready after done", {31'd0, ready_after}, 32'd1);
    end

    // Device leaves data high on the eleventh clock.
    d0 = n_done;
    e0 = n_errp;
    start_byte(8'hED, "noack");
    dev_frame(11, 1'b0, 1'b0, bits);
    wait_result(d0, e0, "noack");
    check("noack error count", n_errp - e0, 1);
    check("noack done count", n_done - d0, 0);
    check("noack oe", {30'd0, err_clk_oe, err_data_oe}, 32'd0);
    check("noack ready after", {31'd0, ready_after}, 32'd1);

    // Device never clocks.
    d0 = n_done;
    e0 = n_errp;
    start_byte(8'h5A, "to0");
    wait_result(d0, e0, "to0");
    check("timeout error count", n_errp - e0, 1);
    check("timeout latency", err_cyc - rel_cyc, TOUT);
    check("timeout oe", {30'd0, err_clk_oe, err_data_oe}, 32'd0);

    // Device stops after five edges.
    d0 = n_done;
    e0 = n_errp;
    start_byte(8'hED, "to5");
    dev_frame(5, 1'b0, 1'b0, bits);
    wait_result(d0, e0, "to5");
    check("stall error count", n_errp - e0, 1);
    check("stall done count", n_done - d0, 0);
    check("stall oe", {30'd0, err_clk_oe, err_data_oe}, 32'd0);
    check("stall ready after", {31'd0, ready_after}, 32'd1);

    // Reset asserted mid-frame, away from any clock edge.
    start_byte(8'h00, "rst");
    dev_frame(4, 1'b0, 1'b0, bits);
    check("data_oe before reset", {31'd0, ps2_data_oe}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midframe reset oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("midframe reset ready", {31'd0, tx_ready}, 32'd0);
    check("midframe reset inhibit", {31'd0, rx_inhibit}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready after midframe reset", {31'd0, tx_ready}, 32'd1);
    d0 = n_done;
    e0 = n_errp;
    start_byte(8'hF4, "post");
    dev_frame(11, 1'b1, 1'b0, bits);
    wait_result(d0, e0, "post");
    check("post reset frame", {21'd0, bits}, {21'd0, 11'h5E8});
    check("post reset done", n_done - d0, 1);

    // Short clock glitches during SEND.
    d0 = n_done;
    e0 = n_errp;
    start_byte(8'hED, "glitch");
    dev_frame(11, 1'b1, 1'b1, bits);
    wait_result(d0, e0, "glitch");
    check("glitch frame", {21'd0, bits}, {21'd0, 11'h7DA});
    check("glitch done", n_done - d0, 1);
    check("glitch error", n_errp - e0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
